multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control state machine for the multi-cycle datapath.
- Drives the write-enable inputs of the datapath's enabled N-bit registers (PC, IR) and memory/register-file strobes.
- Also drives all datapath mux selects and the ALU op class.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles from the IR opcode, with a memory-ready stall.

Parameters:
- OP_W, 6, opcode field width; fixed at 6, kept as a parameter for package alignment only.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  OP_W  IR[31:26]; stable from the cycle after FETCH completes
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle; tie to 1 for single-cycle memory
- pc_en  out  1  PC register Enable
- ir_write  out  1  IR register Enable
- mem_write  out  1  memory write strobe
- reg_write  out  1  register-file write strobe
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_to_reg  out  1  writeback data select: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination select: 0=rt, 1=rd
- alu_src_a  out  1  ALU A select: 0=PC, 1=A
- alu_src_b  out  2  ALU B select: 00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- pc_src  out  2  PC source select: 00=ALU result, 01=ALUOut, 10=jump target
- alu_op  out  2  ALU op class: 00=add, 01=sub, 10=funct
- illegal_op  out  1  one-cycle pulse on undefined opcode
- state_o  out  4  current state, debug only

Behaviour:
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Codes 12-15 are unreachable; if entered, next state = FETCH.
- Reset:
  - rst=1 at a clk edge -> state=FETCH.
  - While rst=1, all outputs are forced to 0 (including illegal_op), regardless of state.
  - Reset mid-instruction abandons it; no partial write strobe is issued in the reset cycle.
- Outputs are Moore-decoded from state. Exceptions: pc_en in BRANCH (uses zero) and enables gated by mem_ready (below). Unlisted outputs are 0.
- FETCH:
  - iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_en = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode: LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP.
  - Any other opcode -> FETCH, with illegal_op=1 this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW->MEMRD, else MEMWR.
- MEMRD: iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEMWR:
  - iord=1, mem_write=mem_ready.
  - Hold until mem_ready=1, then go to FETCH.
  - Exactly one write strobe is issued per SW.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- JUMP: pc_src=10, pc_en=1. Next state FETCH.
- Latency with mem_ready=1 constantly: LW 5 cycles; SW, R, ADDI 4; BEQ, J 3; illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- opcode is don't-care in FETCH; it is sampled combinationally in DECODE and MEMADR only.

Decomposition:
- Shared package holds:
  - opcode constants;
  - state encoding;
  - alu_op codes;
  - alu_src_b / pc_src select encodings (also used by datapath muxes).
- Next-state and output decode are two always blocks in one module; no sub-module.
- The funct-to-ALU-control decoder (alu_decoder) is a separate sibling block, not instantiated here.

Test Plan:
- rst=1 for 2 cycles in any state -> all outputs 0; after release, state_o=0, ir_write=1, pc_en=1 with mem_ready=1.
- LW (100011), mem_ready=1 -> state_o sequence 0,1,2,3,4,0.
  - reg_write=1 only in state 4, with mem_to_reg=1.
  - Exactly one ir_write pulse.
- SW (101011), mem_ready low for 3 cycles in MEMWR -> mem_write=0 for those cycles, then exactly one cycle of mem_write=1, then FETCH.
- BEQ (000100):
  - zero=1 -> pc_en=1 in BRANCH with pc_src=01.
  - zero=0 -> pc_en=0; both cases return to FETCH after 3 cycles total.
- Opcode 111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH, no reg_write or mem_write asserted.
- ADDI then J back-to-back -> 0,1,9,10,0,1,11,0.
  - reg_write only in state 10 with reg_dst=0.
  - pc_src=10 and pc_en=1 in state 11.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle datapath controller: opcodes, state
// numbering, ALU op classes and datapath mux select codes.
package multicycle_control_fsm_pkg;

  localparam int OP_WIDTH = 6;

  localparam logic [OP_WIDTH-1:0] OP_R    = 6'b000000;
  localparam logic [OP_WIDTH-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_WIDTH-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_WIDTH-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_WIDTH-1:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_op(input logic [OP_WIDTH-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle datapath: sequences each instruction
// from the IR opcode and Moore-decodes the datapath strobes and mux selects.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ir_write,
  output logic            mem_write,
  output logic            reg_write,
  output logic            iord,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_src,
  output logic [1:0]      alu_op,
  output logic            illegal_op,
  output logic [3:0]      state_o
);

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem_op(opcode))      state_next = S_MEMADR;
        else if (opcode == OP_R)    state_next = S_EXEC;
        else if (opcode == OP_BEQ)  state_next = S_BRANCH;
        else if (opcode == OP_ADDI) state_next = S_ADDIEX;
        else if (opcode == OP_J)    state_next = S_JUMP;
        else                        state_next = S_FETCH;
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Reset masks every output so an abandoned instruction cannot strobe.
  always_comb begin
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    alu_op     = ALU_ADD;
    illegal_op = 1'b0;
    state_o    = 4'd0;
    if (!rst) begin
      state_o = state_reg;
      case (state_reg)
        S_FETCH: begin
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH2;
          illegal_op = !(is_mem_op(opcode) || opcode == OP_R || opcode == OP_BEQ ||
                         opcode == OP_ADDI || opcode == OP_J);
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = mem_ready;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_en     = zero;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src = PCSRC_JUMP;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: a per-instruction phase list
// and per-phase output table predict every cycle's state and outputs.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal_op;
  } outs_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic [3:0] state_o;
  outs_t      dut_o;

  int checks = 0;
  int failures = 0;

  multicycle_control_fsm #(.OP_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .iord(iord), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign dut_o = {pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
                  alu_src_a, alu_src_b, pc_src, alu_op, illegal_op};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP;
  endfunction

  // Expected outputs for one cycle spent in phase s.
  function automatic outs_t expect_outs(input int s, input logic mr, input logic z,
                                        input logic [5:0] op);
    outs_t e;
    e = '0;
    case (s)
      0:  begin e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
      1:  begin e.alu_src_b = 2'b11; e.illegal_op = !legal(op); end
      2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      3:  e.iord = 1'b1;
      4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      5:  begin e.iord = 1'b1; e.mem_write = mr; end
      6:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
      7:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      8:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; end
      9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      10: e.reg_write = 1'b1;
      11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Entered and left at posedge+1. mem_stall<0 means random stalls;
  // zsel 0/1 forces zero, 2 randomizes; abort_at stops before that phase.
  task automatic run_instr(input logic [5:0] op, input int mem_stall, input int zsel,
                           input int abort_at);
    int seq[$];
    int n, s, cyc, irw, wr;
    logic mr, z;
    cyc = 0; irw = 0; wr = 0;
    seq = {0, 1};
    if (op == LW)        seq = {seq, 2, 3, 4};
    else if (op == SW)   seq = {seq, 2, 5};
    else if (op == RT)   seq = {seq, 6, 7};
    else if (op == BEQ)  seq.push_back(8);
    else if (op == ADDI) seq = {seq, 9, 10};
    else if (op == JMP)  seq.push_back(11);
    for (int p = 0; p < seq.size(); p++) begin
      if (p == abort_at) return;
      s = seq[p];
      if (s == 0)               n = (mem_stall >= 0) ? 0 : $urandom_range(0, 2);
      else if (s == 3 || s == 5) n = (mem_stall >= 0) ? mem_stall : $urandom_range(0, 2);
      else                      n = 0;
      for (int k = 0; k <= n; k++) begin
        if (s == 0 || s == 3 || s == 5) mr = (k == n);
        else                            mr = 1'($urandom_range(0, 1));
        z = (zsel == 2) ? 1'($urandom_range(0, 1)) : zsel[0];
        mem_ready = mr;
        zero = z;
        opcode = (s == 0) ? 6'($urandom) : op;
        @(negedge clk);
        chk("state", 32'(state_o), 32'(s));
        chk("outs", 32'(dut_o), 32'(expect_outs(s, mr, z, op)));
        cyc++;
        irw += int'(ir_write);
        wr += int'(mem_write);
        @(posedge clk);
        #1;
      end
    end
    chk("ir_pulses", 32'(irw), 32'd1);
    chk("mem_write_pulses", 32'(wr), (op == SW) ? 32'd1 : 32'd0);
    $display("instr op=%b cycles=%0d states=%0d", op, cyc, seq.size());
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      opcode = 6'($urandom);
      @(negedge clk);
      chk("rst_outs", 32'(dut_o), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    $display("reset cycles=%0d", cycles);
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    run_instr(LW, 0, 2, -1);
    run_instr(SW, 3, 2, -1);
    run_instr(BEQ, 0, 1, -1);
    run_instr(BEQ, 0, 0, -1);
    run_instr(6'b111111, 0, 2, -1);
    run_instr(ADDI, 0, 2, -1);
    run_instr(JMP, 0, 2, -1);
    run_instr(RT, 0, 2, -1);
    run_instr(LW, 3, 2, 3);
    do_reset(2);
    run_instr(LW, 0, 2, -1);
    run_instr(SW, 2, 2, 3);
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, -1, 2, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
